// File: rtl/ro_scan_pkg.sv
// Shared definitions for the ring-oscillator scan meter: FSM encoding and
// the averaging-depth clamp.
package ro_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_GATE   = 3'd2,
    ST_ACCUM  = 3'd3,
    ST_OUT    = 3'd4
  } state_e;

  // Largest log2 of the number of windows averaged per result.
  localparam int unsigned AVG_MAX_LIM = 7;

  // Limit a requested averaging depth to what the accumulator can hold.
  function automatic logic [2:0] clamp_avg(input logic [2:0] req, input int unsigned lim);
    return (32'(req) > lim) ? 3'(lim) : req;
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Rising-edge counter for one asynchronous oscillator input: 2-FF
// synchroniser, previous-value register, and a saturating counter that is
// cleared between windows and only advances while the gate is open.
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             osc_i,
  input  logic             clr_i,
  input  logic             gate_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic             s1_q, s2_q, s3_q;
  logic             rise_w;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  // Bring the oscillator into the clk domain and keep one delayed copy.
  always_ff @(posedge clk_i) begin
    s1_q <= osc_i;
    s2_q <= s1_q;
    s3_q <= s2_q;
  end

  assign rise_w = s2_q & ~s3_q;

  // Count gated rising edges; an edge arriving at full scale flags overflow.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (gate_i && rise_w) begin
      if (cnt_q == '1) ovf_q <= 1'b1;
      else             cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/ro_scan_meter.sv
// N-channel ring-oscillator frequency meter. One RO is enabled at a time,
// allowed to settle, then its edges are counted over 2^avg gate windows;
// the truncated mean is offered on a valid/ready port. Optional round-robin
// scan walks all channels until the scan input is dropped.
module ro_scan_meter
  import ro_scan_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CH_W       = 2,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int AVG_MAX    = AVG_MAX_LIM,
  parameter int SETTLE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [N_CH-1:0]  osc_in,
  output logic [N_CH-1:0]  osc_en,
  input  logic             start,
  input  logic             scan,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic [WIN_W-1:0] win_len,
  input  logic [2:0]       avg_log2,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_data,
  output logic [CH_W-1:0]  res_ch,
  output logic             res_ovf
);

  localparam int ACC_W  = CNT_W + AVG_MAX;
  localparam int SAMP_W = AVG_MAX + 1;
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              scan_q, scan_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [WIN_W-1:0]  wcnt_q, wcnt_d;
  logic [2:0]        avg_q, avg_d;
  logic [SET_W-1:0]  set_q, set_d;
  logic [SAMP_W-1:0] samp_q, samp_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              vld_q, vld_d;
  logic [CNT_W-1:0]  rdata_q, rdata_d;
  logic [CH_W-1:0]   rch_q, rch_d;
  logic              rovf_q, rovf_d;

  logic [CNT_W-1:0]  win_cnt;
  logic              win_ovf;
  logic [SAMP_W-1:0] samp_inc;
  logic [SAMP_W-1:0] n_win;

  // Selected channel only changes when leaving IDLE or OUT, so the
  // synchroniser is flushed by the settle period before any gate opens.
  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i  (clk),
    .osc_i  (osc_in[ch_q]),
    .clr_i  (state_q != ST_GATE),
    .gate_i (state_q == ST_GATE),
    .cnt_o  (win_cnt),
    .ovf_o  (win_ovf)
  );

  assign samp_inc = samp_q + SAMP_W'(1);
  assign n_win    = SAMP_W'(1) << avg_q;

  assign osc_en    = (state_q == ST_IDLE) ? '0 : (N_CH'(1) << ch_q);
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = vld_q;
  assign res_data  = rdata_q;
  assign res_ch    = rch_q;
  assign res_ovf   = rovf_q;

  // State and datapath registers; reset returns everything to idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      scan_q  <= 1'b0;
      win_q   <= WIN_W'(1);
      wcnt_q  <= '0;
      avg_q   <= '0;
      set_q   <= '0;
      samp_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      rdata_q <= '0;
      rch_q   <= '0;
      rovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      scan_q  <= scan_d;
      win_q   <= win_d;
      wcnt_q  <= wcnt_d;
      avg_q   <= avg_d;
      set_q   <= set_d;
      samp_q  <= samp_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      rdata_q <= rdata_d;
      rch_q   <= rch_d;
      rovf_q  <= rovf_d;
    end
  end

  // Measurement sequencer: settle, gate/accumulate 2^avg windows, present result.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    scan_d  = scan_q;
    win_d   = win_q;
    wcnt_d  = wcnt_q;
    avg_d   = avg_q;
    set_d   = set_q;
    samp_d  = samp_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    rdata_d = rdata_q;
    rch_d   = rch_q;
    rovf_d  = rovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ch_d    = ch_sel;
          scan_d  = scan;
          win_d   = (win_len == '0) ? WIN_W'(1) : win_len;
          avg_d   = clamp_avg(avg_log2, AVG_MAX);
          acc_d   = '0;
          samp_d  = '0;
          ovf_d   = 1'b0;
          set_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (set_q == SET_W'(SETTLE_CYC - 1)) begin
          set_d   = '0;
          wcnt_d  = '0;
          state_d = ST_GATE;
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end
      ST_GATE: begin
        if (wcnt_q == win_q - WIN_W'(1)) begin
          wcnt_d  = '0;
          state_d = ST_ACCUM;
        end else begin
          wcnt_d = wcnt_q + WIN_W'(1);
        end
      end
      ST_ACCUM: begin
        acc_d   = acc_q + ACC_W'(win_cnt);
        ovf_d   = ovf_q | win_ovf;
        samp_d  = samp_inc;
        state_d = (samp_inc < n_win) ? ST_GATE : ST_OUT;
      end
      ST_OUT: begin
        if (!vld_q) begin
          vld_d   = 1'b1;
          rdata_d = CNT_W'(acc_q >> avg_q);
          rch_d   = ch_q;
          rovf_d  = ovf_q;
        end else if (res_ready) begin
          vld_d = 1'b0;
          if (scan_q && scan) begin
            ch_d    = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
            acc_d   = '0;
            samp_d  = '0;
            ovf_d   = 1'b0;
            set_d   = '0;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!ena) begin
      state_d = ST_IDLE;
      vld_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_ro_scan_meter.sv
// Bench for ro_scan_meter: deterministic oscillator sources, a schedule-based
// reference model checked every cycle, and directed scenarios with
// hand-computed expectations.
module tb_ro_scan_meter;

  localparam int N = 4;
  localparam int S = 16;

  logic        clk;
  logic        rst, ena, start, scan, res_ready;
  logic [3:0]  osc_in;
  logic [1:0]  ch_sel;
  logic [15:0] win_len;
  logic [2:0]  avg_log2;

  logic [3:0]  osc_en, s_osc_en;
  logic        busy, res_valid, res_ovf, s_busy, s_valid, s_ovf;
  logic [15:0] res_data;
  logic [7:0]  s_data;
  logic [1:0]  res_ch, s_ch;

  ro_scan_meter u_dut (
    .clk(clk), .rst(rst), .ena(ena), .osc_in(osc_in), .osc_en(osc_en),
    .start(start), .scan(scan), .ch_sel(ch_sel), .win_len(win_len),
    .avg_log2(avg_log2), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_ch(res_ch), .res_ovf(res_ovf)
  );

  ro_scan_meter #(.CNT_W(8)) u_small (
    .clk(clk), .rst(rst), .ena(ena), .osc_in(osc_in), .osc_en(s_osc_en),
    .start(start), .scan(scan), .ch_sel(ch_sel), .win_len(win_len),
    .avg_log2(avg_log2), .busy(s_busy), .res_valid(s_valid),
    .res_ready(res_ready), .res_data(s_data), .res_ch(s_ch), .res_ovf(s_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", nm, act, lo, hi, $time);
    end
  endtask

  // Oscillator sources: square wave of per[c] clk cycles, or manual level when per[c]==0.
  int         per[N];
  logic [3:0] man;
  int         gcyc;
  initial begin
    gcyc   = 0;
    osc_in = '0;
    forever begin
      @(negedge clk);
      gcyc++;
      for (int c = 0; c < N; c++)
        osc_in[c] = (per[c] != 0) ? ((gcyc % per[c]) < (per[c] / 2)) : man[c];
    end
  end

  // Reference model: a run that starts at edge k settles for S cycles, then
  // uses windows of W gate cycles plus one accumulate cycle each; the result
  // appears one cycle after the last window's slot ends.
  bit         m_init, m_act, m_valid, m_scan, m_ovf, m_sovf, m_wovf;
  int         m_k, m_ch, m_W, m_avg, m_sum, m_wcnt, m_data, m_chout;
  int         cyc, rel, pos, nwin;
  logic [3:0] xp1, xp2;
  int         vld_rise, vld_fall;
  logic       prev_v;

  initial begin
    m_init = 0; m_act = 0; m_valid = 0; m_data = 0; m_chout = 0; m_ovf = 0;
    cyc = 0; xp1 = '0; xp2 = '0; vld_rise = 0; vld_fall = 0; prev_v = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_init = 1; m_act = 0; m_valid = 0; m_data = 0; m_chout = 0; m_ovf = 0;
      end else if (!ena) begin
        m_act = 0; m_valid = 0;
      end else if (!m_act) begin
        if (start) begin
          m_act = 1; m_k = cyc; m_ch = ch_sel; m_scan = scan;
          m_W = (win_len == 0) ? 1 : win_len;
          m_avg = avg_log2;
          m_sum = 0; m_sovf = 0; m_wcnt = 0; m_wovf = 0;
        end
      end else if (m_valid) begin
        if (res_ready) begin
          m_valid = 0;
          if (m_scan && scan) begin
            m_ch = (m_ch + 1) % N; m_k = cyc;
            m_sum = 0; m_sovf = 0; m_wcnt = 0; m_wovf = 0;
          end else begin
            m_act = 0;
          end
        end
      end else begin
        rel  = cyc - m_k - S;
        nwin = 1 << m_avg;
        if (rel >= 0 && rel < nwin * (m_W + 1)) begin
          pos = rel % (m_W + 1);
          if (pos < m_W) begin
            if (xp1[m_ch] && !xp2[m_ch]) begin
              if (m_wcnt == 65535) m_wovf = 1;
              else m_wcnt++;
            end
          end else begin
            m_sum += m_wcnt; m_sovf |= m_wovf; m_wcnt = 0; m_wovf = 0;
          end
        end else if (rel == nwin * (m_W + 1) + 1) begin
          m_valid = 1; m_data = m_sum >> m_avg; m_chout = m_ch; m_ovf = m_sovf;
        end
      end
      xp2 = xp1;
      xp1 = osc_in;
      cyc++;
      #1;
      if (res_valid && !prev_v) vld_rise++;
      if (!res_valid && prev_v) vld_fall++;
      prev_v = res_valid;
      if (m_init) begin
        chk("busy", busy, m_act);
        chk("osc_en", osc_en, m_act ? (1 << m_ch) : 0);
        chk("res_valid", res_valid, m_valid);
        chk("res_data", res_data, m_data);
        chk("res_ch", res_ch, m_chout);
        chk("res_ovf", res_ovf, m_ovf);
      end
    end
  end

  task automatic go(input int ch, input bit sc, input int w, input int a);
    @(negedge clk);
    ch_sel = 2'(ch); scan = sc; win_len = 16'(w); avg_log2 = 3'(a); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the number of negedges observed since the start edge (1 = right after it).
  task automatic wait_valid(output int n);
    n = 1;
    while (!res_valid && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", res_valid, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int lat, r0, f0, d0;
  int exp_ch[5] = '{2, 3, 0, 1, 2};
  int exp_d[5]  = '{12, 10, 20, 15, 12};
  int wcnts[4]  = '{8, 9, 10, 11};
  int p, tgt;

  initial begin
    rst = 1; ena = 1; start = 0; scan = 0; res_ready = 1;
    ch_sel = 0; win_len = 0; avg_log2 = 0; man = '0;
    for (int c = 0; c < N; c++) per[c] = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_osc_en", osc_en, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    // Single shot, ch1, period 10, 100-cycle window
    per[1] = 10;
    go(1, 0, 100, 0);
    wait_valid(lat);
    chk("t1_latency", lat - 1, S + 102);
    chk_rng("t1_data", res_data, 9, 11);
    chk("t1_ch", res_ch, 1);
    chk("t1_ovf", res_ovf, 0);
    @(negedge clk);
    chk("t1_valid_drop", res_valid, 0);
    chk("t1_idle", busy, 0);

    // Averaging of window counts 8,9,10,11 -> 9
    per[0] = 0; man[0] = 0;
    r0 = vld_rise;
    go(0, 0, 60, 2);
    p = 0;
    for (int i = 0; i < 4; i++) begin
      tgt = S + i * 61 + 8;
      repeat (tgt - p) @(negedge clk);
      p = tgt;
      for (int q = 0; q < wcnts[i]; q++) begin
        man[0] = 1; repeat (2) @(negedge clk);
        man[0] = 0; repeat (2) @(negedge clk);
      end
      p += 4 * wcnts[i];
    end
    wait_valid(lat);
    chk("t2_avg", res_data, 9);
    chk("t2_ch", res_ch, 0);
    repeat (5) @(negedge clk);
    chk("t2_one_valid", vld_rise - r0, 1);

    // Saturation on the 8-bit instance, then a clean run clears the flag
    per[0] = 4;
    go(0, 0, 2000, 0);
    wait_valid(lat);
    chk("t3_small_data", s_data, 255);
    chk("t3_small_ovf", s_ovf, 1);
    chk_rng("t3_main_data", res_data, 499, 501);
    chk("t3_main_ovf", res_ovf, 0);
    @(negedge clk);
    per[2] = 10;
    go(2, 0, 100, 0);
    wait_valid(lat);
    chk("t3_clean_ovf", s_ovf, 0);
    chk_rng("t3_clean_data", s_data, 9, 11);
    @(negedge clk);

    // Round-robin scan from ch2 with distinct periods
    per[0] = 6; per[1] = 8; per[2] = 10; per[3] = 12;
    go(2, 1, 120, 0);
    for (int j = 0; j < 5; j++) begin
      wait_valid(lat);
      chk("t4_ch", res_ch, exp_ch[j]);
      chk_rng("t4_data", res_data, exp_d[j] - 1, exp_d[j] + 1);
      @(negedge clk);
      if (j == 3) scan = 0;
    end
    chk("t4_idle_after_drop", busy, 0);

    // Backpressure: hold the result for 50 cycles
    res_ready = 0;
    f0 = vld_fall;
    go(3, 0, 60, 1);
    wait_valid(lat);
    d0 = res_data;
    chk_rng("t5_data", res_data, 4, 6);
    repeat (50) @(negedge clk);
    chk("t5_hold_valid", res_valid, 1);
    chk("t5_hold_data", res_data, d0);
    chk("t5_hold_ch", res_ch, 3);
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("t5_valid_drop", res_valid, 0);
    repeat (5) @(negedge clk);
    chk("t5_one_beat", vld_fall - f0, 1);
    res_ready = 1;

    // Reset pulse while gating
    go(1, 0, 100, 0);
    repeat (S + 10) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_osc_en", osc_en, 0);
    chk("t6_rst_valid", res_valid, 0);
    chk("t6_rst_data", res_data, 0);
    chk("t6_rst_ch", res_ch, 0);
    chk("t6_rst_ovf", res_ovf, 0);
    rst = 0;
    @(negedge clk);

    // ena low while a result waits
    res_ready = 0;
    go(1, 0, 20, 0);
    wait_valid(lat);
    ena = 0;
    @(negedge clk);
    chk("t6_ena_valid", res_valid, 0);
    chk("t6_ena_osc_en", osc_en, 0);
    chk("t6_ena_busy", busy, 0);
    ena = 1; res_ready = 1;
    repeat (3) @(negedge clk);
    chk("t6_discarded", res_valid, 0);

    // win_len 0 behaves as a 1-cycle gate
    go(1, 0, 0, 0);
    wait_valid(lat);
    chk("t6_win0_latency", lat - 1, S + 3);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
